// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first,
// sequenced by a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   acc_sr;
    logic [WIDTH-1:0]   acc_nxt;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               bit_s;
    logic               bit_c;

    // Single full-adder cell on the current LSBs
    assign bit_s = a_sr[0] ^ b_sr[0] ^ carry;
    assign bit_c = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

    // New sum bit enters the result register from the top
    if (WIDTH == 1) begin : gen_acc_w1
        assign acc_nxt = bit_s;
    end else begin : gen_acc_wn
        assign acc_nxt = {bit_s, acc_sr[WIDTH-1:1]};
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register with registered busy/done decodes of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    // Operand capture, bit-serial shifting and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            acc_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc_sr <= acc_nxt;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= bit_c;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        sum  <= acc_nxt;
                        cout <= bit_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed WIDTH=8 scenarios, random ops
// and an exhaustive WIDTH=4 sweep against a plain a+b+cin model.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int checks;
    int failures;

    logic [7:0] last_sum8;
    logic       last_cout8;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called one cycle after the start edge E; follows the op through DONE and one idle cycle
    task automatic finish8(input logic [8:0] expv);
        for (int k = 1; k < 8; k++) begin
            tick;
            check("run_busy", 32'(busy8), 32'(1));
            check("run_done", 32'(done8), 32'(0));
            check("run_sum_hold", 32'(sum8), 32'(last_sum8));
            check("run_cout_hold", 32'(cout8), 32'(last_cout8));
        end
        tick;
        check("done_busy", 32'(busy8), 32'(0));
        check("done_pulse", 32'(done8), 32'(1));
        check("done_sum", 32'(sum8), 32'(expv[7:0]));
        check("done_cout", 32'(cout8), 32'(expv[8]));
        last_sum8  = expv[7:0];
        last_cout8 = expv[8];
        tick;
        check("post_done", 32'(done8), 32'(0));
        check("post_busy", 32'(busy8), 32'(0));
        check("post_sum_hold", 32'(sum8), 32'(last_sum8));
        check("post_cout_hold", 32'(cout8), 32'(last_cout8));
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        logic [8:0] expv;
        expv   = 9'(ta) + 9'(tb) + 9'(tc);
        a8     = ta;
        b8     = tb;
        cin8   = tc;
        start8 = 1'b1;
        tick;
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
        check("start_busy", 32'(busy8), 32'(1));
        finish8(expv);
    endtask

    initial begin
        logic [4:0] q[$];
        logic [4:0] e4;
        logic       prev_busy;
        int         idx;
        int         ndone;
        int         cyc;

        checks     = 0;
        failures   = 0;
        last_sum8  = '0;
        last_cout8 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        // Reset, then 20 idle cycles with everything at zero
        rst_n = 1'b0;
        #23;
        check("rst_busy", 32'(busy8), 32'(0));
        check("rst_done", 32'(done8), 32'(0));
        check("rst_sum", 32'(sum8), 32'(0));
        check("rst_cout", 32'(cout8), 32'(0));
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick;
            check("idle_busy", 32'(busy8), 32'(0));
            check("idle_done", 32'(done8), 32'(0));
            check("idle_sum", 32'(sum8), 32'(0));
            check("idle_cout", 32'(cout8), 32'(0));
        end
        check("idle_busy4", 32'(busy4), 32'(0));

        // start held across reset release is taken on the first edge
        #2 rst_n = 1'b0;
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick;
        start8 = 1'b0;
        check("rel_start_busy", 32'(busy8), 32'(1));
        finish8(9'h033);

        // Directed operations
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'hA5, 8'h5A, 1'b1);
        run8(8'hA5, 8'h5A, 1'b0);

        // Start during RUN is ignored; start held through DONE is taken at E+10
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        check("ign_busy_E", 32'(busy8), 32'(1));
        tick;
        tick;
        a8 = 8'hFF; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        check("ign_busy", 32'(busy8), 32'(1));
        a8 = 8'h20; b8 = 8'h30; cin8 = 1'b1; start8 = 1'b1;
        for (int k = 4; k < 8; k++) begin
            tick;
            check("ign_run_busy", 32'(busy8), 32'(1));
            check("ign_run_done", 32'(done8), 32'(0));
            check("ign_sum_hold", 32'(sum8), 32'(last_sum8));
        end
        tick;
        check("ign_done", 32'(done8), 32'(1));
        check("ign_sum", 32'(sum8), 32'h07);
        check("ign_cout", 32'(cout8), 32'(0));
        last_sum8 = 8'h07; last_cout8 = 1'b0;
        tick;
        check("held_idle_busy", 32'(busy8), 32'(0));
        check("held_idle_done", 32'(done8), 32'(0));
        tick;
        start8 = 1'b0;
        check("held_accept_busy", 32'(busy8), 32'(1));
        finish8(9'h051);

        // Reset in the middle of RUN aborts the op and clears the result
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        for (int k = 0; k < 4; k++) tick;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy8), 32'(0));
        check("mid_rst_done", 32'(done8), 32'(0));
        check("mid_rst_sum", 32'(sum8), 32'(0));
        check("mid_rst_cout", 32'(cout8), 32'(0));
        last_sum8 = '0; last_cout8 = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick;
            check("abort_no_done", 32'(done8), 32'(0));
            check("abort_no_busy", 32'(busy8), 32'(0));
        end
        run8(8'h12, 8'h34, 1'b0);

        // Random operations
        for (int k = 0; k < 16; k++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Exhaustive WIDTH=4 sweep, back-to-back with start held
        q         = {};
        idx       = 0;
        ndone     = 0;
        cyc       = 0;
        prev_busy = 1'b0;
        {cin4, b4, a4} = 9'(0);
        start4 = 1'b1;
        while (ndone < 512 && cyc < 4000) begin
            tick;
            cyc++;
            if (busy4 && !prev_busy) begin
                q.push_back(5'(a4) + 5'(b4) + 5'(cin4));
                idx++;
                if (idx < 512) {cin4, b4, a4} = 9'(idx);
                else start4 = 1'b0;
            end
            if (done4) begin
                ndone++;
                if (q.size() > 0) begin
                    e4 = q.pop_front();
                    check("ex_sum", 32'(sum4), 32'(e4[3:0]));
                    check("ex_cout", 32'(cout4), 32'(e4[4]));
                end else begin
                    check("ex_unexpected_done", 32'(done4), 32'(0));
                end
            end
            prev_busy = busy4;
        end
        check("ex_done_count", 32'(ndone), 32'(512));
        check("ex_accept_count", 32'(idx), 32'(512));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
